// File: rtl/led_pkg.sv
// Shared types and default sizes for the LED row scheduler and the HPS I/O register block.
package led_pkg;

   localparam int NB_LED_BAND_DEF = 20;
   localparam int NB_MUX_ROWS_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_BLANK = 3'd4,
      S_LATCH = 3'd5
   } sched_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_row_scheduler_if.sv
// Frame-buffer read stream into the scheduler.
// A beat transfers on every cycle where data_valid and data_ready are both high; data is sampled only then.
interface led_row_scheduler_if #(
   parameter int NB_LED_BAND = led_pkg::NB_LED_BAND_DEF
) ();

   logic [NB_LED_BAND-1:0] data;
   logic                   data_valid;
   logic                   data_ready;

   modport master (output data, output data_valid, input data_ready);
   modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/sclk_gen.sv
// Phase counter for one SCLK beat: a low phase then a high phase, each SCLK_DIV clocks long.
module sclk_gen
   import led_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic start_beat,
   output logic phase_done,
   output logic sclk_level
);

   localparam int CW = cnt_w(SCLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          active_q, active_d;
   logic          level_q, level_d;

   always_comb begin
      cnt_d      = cnt_q;
      active_d   = active_q;
      level_d    = level_q;
      phase_done = active_q && (cnt_q == CW'(SCLK_DIV - 1));
      if (clear) begin
         cnt_d    = '0;
         active_d = 1'b0;
         level_d  = 1'b0;
      end else if (start_beat) begin
         cnt_d    = '0;
         active_d = 1'b1;
         level_d  = 1'b0;
      end else if (phase_done) begin
         // The end of the high phase also ends the beat.
         cnt_d    = '0;
         level_d  = !level_q;
         active_d = !level_q;
      end else if (active_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         level_q  <= level_d;
      end
   end

   assign sclk_level = level_q;

endmodule

// File: rtl/led_row_scheduler.sv
// Drives one multiplexed LED frame: per row shift a column, blank, latch, enable the row.
// The HPS can take over the pins at any time through hps_override.
module led_row_scheduler
   import led_pkg::*;
#(
   parameter int  NB_LED_BAND  = NB_LED_BAND_DEF,
   parameter int  NB_MUX_ROWS  = NB_MUX_ROWS_DEF,
   parameter int  SHIFT_BITS   = 48,
   parameter int  SCLK_DIV     = 2,
   parameter int  BLANK_CYCLES = 4,
   localparam int ROW_W        = cnt_w(NB_MUX_ROWS)
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   start,
   input  logic                   hps_override,
   input  logic [NB_LED_BAND-1:0] hps_SOUT,
   input  logic                   hps_SCLK,
   input  logic                   hps_LAT,
   input  logic [NB_MUX_ROWS-1:0] hps_row_en,
   led_row_scheduler_if.slave     rd,
   output logic [NB_LED_BAND-1:0] SOUT,
   output logic                   SCLK,
   output logic                   LAT,
   output logic [NB_MUX_ROWS-1:0] row_en,
   output logic [ROW_W-1:0]       row_idx,
   output logic                   busy,
   output logic                   start_missed,
   output sched_state_t           state_dbg
);

   localparam int BIT_W = cnt_w(SHIFT_BITS);
   localparam int BLK_W = cnt_w(BLANK_CYCLES);

   sched_state_t           state_q, state_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [BLK_W-1:0]       blank_q, blank_d;
   logic [NB_LED_BAND-1:0] sout_q, sout_d;
   logic                   lat_q, lat_d;
   logic [NB_MUX_ROWS-1:0] row_en_q, row_en_d;
   logic                   start_missed_q, start_missed_d;
   logic                   start_beat;
   logic                   phase_done;
   logic                   sclk_level;

   sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
      .clk        (clk),
      .rst        (rst_in),
      .clear      (hps_override),
      .start_beat (start_beat),
      .phase_done (phase_done),
      .sclk_level (sclk_level)
   );

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      bit_d          = bit_q;
      blank_d        = blank_q;
      sout_d         = sout_q;
      lat_d          = lat_q;
      row_en_d       = row_en_q;
      start_beat     = 1'b0;
      start_missed_d = start && (state_q != S_IDLE) && !hps_override;
      if (hps_override) begin
         // HPS owns the pins: park everything so release starts from a clean IDLE.
         state_d  = S_IDLE;
         row_d    = '0;
         bit_d    = '0;
         blank_d  = '0;
         sout_d   = '0;
         lat_d    = 1'b0;
         row_en_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_LOAD;
                  row_d   = '0;
                  bit_d   = '0;
               end
            end
            S_LOAD: begin
               if (rd.data_valid) begin
                  sout_d     = rd.data;
                  start_beat = 1'b1;
                  state_d    = S_LOW;
               end
            end
            S_LOW: begin
               if (phase_done) state_d = S_HIGH;
            end
            S_HIGH: begin
               if (phase_done) begin
                  if (bit_q == BIT_W'(SHIFT_BITS - 1)) begin
                     bit_d    = '0;
                     blank_d  = '0;
                     row_en_d = '0;
                     state_d  = S_BLANK;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     state_d = S_LOAD;
                  end
               end
            end
            S_BLANK: begin
               if (blank_q == BLK_W'(BLANK_CYCLES - 1)) begin
                  blank_d = '0;
                  lat_d   = 1'b1;
                  state_d = S_LATCH;
               end else begin
                  blank_d = blank_q + 1'b1;
               end
            end
            S_LATCH: begin
               lat_d    = 1'b0;
               row_en_d = NB_MUX_ROWS'(1) << row_q;
               if (row_q == ROW_W'(NB_MUX_ROWS - 1)) begin
                  row_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= S_IDLE;
         row_q          <= '0;
         bit_q          <= '0;
         blank_q        <= '0;
         sout_q         <= '0;
         lat_q          <= 1'b0;
         row_en_q       <= '0;
         start_missed_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         bit_q          <= bit_d;
         blank_q        <= blank_d;
         sout_q         <= sout_d;
         lat_q          <= lat_d;
         row_en_q       <= row_en_d;
         start_missed_q <= start_missed_d;
      end
   end

   assign rd.data_ready = (state_q == S_LOAD) && !hps_override;
   assign busy          = (state_q != S_IDLE);
   assign row_idx       = row_q;
   assign start_missed  = start_missed_q;
   assign state_dbg     = state_q;

   assign SOUT   = hps_override ? hps_SOUT   : sout_q;
   assign SCLK   = hps_override ? hps_SCLK   : sclk_level;
   assign LAT    = hps_override ? hps_LAT    : lat_q;
   assign row_en = hps_override ? hps_row_en : row_en_q;

endmodule

// File: tb/tb_led_row_scheduler.sv
// Bench for led_row_scheduler: override/idle vector table, whole-frame runs against a timeline model,
// and hand sequences for stall, duplicate start, override takeover and reset during latch.
module tb_led_row_scheduler;
   import led_pkg::*;

   localparam int NB   = 20;
   localparam int NR   = 4;
   localparam int SB   = 48;
   localparam int DIV  = 2;
   localparam int BLK  = 4;
   localparam int MAXC = 2000;

   logic          clk = 1'b0;
   logic          rst_in = 1'b1;
   logic          start = 1'b0;
   logic          hps_override = 1'b0;
   logic [NB-1:0] hps_SOUT = '0;
   logic          hps_SCLK = 1'b0;
   logic          hps_LAT = 1'b0;
   logic [NR-1:0] hps_row_en = '0;
   logic [NB-1:0] SOUT;
   logic          SCLK;
   logic          LAT;
   logic [NR-1:0] row_en;
   logic [1:0]    row_idx;
   logic          busy;
   logic          start_missed;
   sched_state_t  state_dbg;

   led_row_scheduler_if #(.NB_LED_BAND(NB)) rd_if ();

   led_row_scheduler #(
      .NB_LED_BAND(NB), .NB_MUX_ROWS(NR), .SHIFT_BITS(SB), .SCLK_DIV(DIV), .BLANK_CYCLES(BLK)
   ) dut (
      .clk          (clk),
      .rst_in       (rst_in),
      .start        (start),
      .hps_override (hps_override),
      .hps_SOUT     (hps_SOUT),
      .hps_SCLK     (hps_SCLK),
      .hps_LAT      (hps_LAT),
      .hps_row_en   (hps_row_en),
      .rd           (rd_if),
      .SOUT         (SOUT),
      .SCLK         (SCLK),
      .LAT          (LAT),
      .row_en       (row_en),
      .row_idx      (row_idx),
      .busy         (busy),
      .start_missed (start_missed),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic          vld [MAXC];
   logic [NB-1:0] dat [MAXC];
   logic [NB-1:0] exp_q[$];
   int            exp_rise_q[$];
   int            exp_lat_q[$];
   int            lat_obs [NR];
   int            busy_obs;

   typedef struct {
      logic          ovr;
      logic [NB-1:0] h_sout;
      logic          h_sclk;
      logic          h_lat;
      logic [NR-1:0] h_row;
      logic          st;
      logic [NB-1:0] e_sout;
      logic          e_sclk;
      logic          e_lat;
      logic [NR-1:0] e_row;
      logic          e_ready;
      logic          e_busy;
      logic          e_missed;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Builds a random stimulus timeline, derives the expected event times from the
   // beat/blank/latch durations, then runs one frame and checks every observed event.
   task automatic run_frame(input bit rand_valid, input int stall_at, input int stall_len, input bit dup);
      int t, exp_end, dup_c, rises, nlat, last_lat, busy_last, missed;
      logic prev_sclk;
      logic [NB-1:0] hold;
      for (int i = 0; i < MAXC; i++) begin
         vld[i] = (!rand_valid || i >= MAXC - 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (i >= stall_at && i < stall_at + stall_len) vld[i] = 1'b0;
         dat[i] = NB'($urandom);
      end
      exp_q.delete();
      exp_rise_q.delete();
      exp_lat_q.delete();
      t = 1;
      for (int r = 0; r < NR; r++) begin
         for (int b = 0; b < SB; b++) begin
            while (!vld[t]) t++;
            exp_q.push_back(dat[t]);
            exp_rise_q.push_back(t + 1 + DIV);
            t += 1 + 2 * DIV;
         end
         t += BLK;
         exp_lat_q.push_back(t);
         t++;
      end
      exp_end = t - 1;
      dup_c = dup ? exp_lat_q[1] + 20 : -5;

      @(posedge clk); #1;
      start = 1'b1;
      rd_if.data_valid = vld[0];
      rd_if.data = dat[0];
      rises = 0; nlat = 0; last_lat = -10; busy_last = 0; missed = 0;
      prev_sclk = 1'b0; hold = '0;
      for (int c = 1; c <= exp_end + 2; c++) begin
         @(posedge clk); #1;
         start = (c == dup_c);
         rd_if.data_valid = vld[c];
         rd_if.data = dat[c];
         #1;
         if (busy) busy_last = c;
         if (start_missed) missed++;
         if (c == dup_c + 1) check("start_missed_pulse", start_missed, 1);
         if (SCLK && !prev_sclk) begin
            rises++;
            if (exp_rise_q.size() == 0) check("sclk_rise_extra", rises, NR * SB);
            else begin
               check("sclk_rise_cycle", c, exp_rise_q.pop_front());
               check("sout_beat", SOUT, exp_q.pop_front());
            end
         end
         prev_sclk = SCLK;
         if (exp_lat_q.size() > 0 && c == exp_lat_q[0] - 1) check("row_en_blank", row_en, 0);
         if (LAT) begin
            if (nlat < NR) lat_obs[nlat] = c;
            nlat++;
            last_lat = c;
            if (exp_lat_q.size() == 0) check("lat_extra", nlat, NR);
            else check("lat_cycle", c, exp_lat_q.pop_front());
         end
         if (c == last_lat + 1) check("row_en_after_lat", row_en, 32'(1) << (nlat - 1));
         if (stall_len > 0) begin
            if (c == stall_at - 1) hold = SOUT;
            if (c >= stall_at && c <= stall_at + stall_len) begin
               check("stall_sclk_low", SCLK, 0);
               check("stall_sout_hold", SOUT, hold);
            end
         end
      end
      start = 1'b0;
      rd_if.data_valid = 1'b0;
      busy_obs = busy_last;
      check("busy_last_cycle", busy_last, exp_end);
      check("sclk_rise_total", rises, NR * SB);
      check("lat_total", nlat, NR);
      check("start_missed_count", missed, dup ? 1 : 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      //          ovr   h_sout     sclk  lat   h_row    st    e_sout     sclk  lat   e_row    rdy   busy  missed
      vecs[0] = '{1'b0, 20'hFFFFF, 1'b1, 1'b1, 4'b1111, 1'b0, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 20'hABCDE, 1'b1, 1'b0, 4'b0101, 1'b0, 20'hABCDE, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 20'h12345, 1'b0, 1'b1, 4'b1010, 1'b1, 20'h12345, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b1, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 20'h55555, 1'b1, 1'b1, 4'b0011, 1'b0, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 20'hFFFFF, 1'b1, 1'b1, 4'b1111, 1'b0, 20'hFFFFF, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b0, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

      rd_if.data = '0;
      rd_if.data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_in = 1'b0;
      #1;
      check("rst_sout", SOUT, 0);
      check("rst_sclk", SCLK, 0);
      check("rst_lat", LAT, 0);
      check("rst_row_en", row_en, 0);
      check("rst_busy", busy, 0);
      check("rst_row_idx", row_idx, 0);
      check("rst_start_missed", start_missed, 0);
      check("rst_data_ready", rd_if.data_ready, 0);
      check("rst_state", state_dbg, S_IDLE);

      for (int i = 0; i < 7; i++) begin
         hps_override = vecs[i].ovr;
         hps_SOUT     = vecs[i].h_sout;
         hps_SCLK     = vecs[i].h_sclk;
         hps_LAT      = vecs[i].h_lat;
         hps_row_en   = vecs[i].h_row;
         start        = vecs[i].st;
         #1;
         check("vec_sout", SOUT, vecs[i].e_sout);
         check("vec_sclk", SCLK, vecs[i].e_sclk);
         check("vec_lat", LAT, vecs[i].e_lat);
         check("vec_row_en", row_en, vecs[i].e_row);
         check("vec_data_ready", rd_if.data_ready, vecs[i].e_ready);
         @(posedge clk); #1;
         start = 1'b0;
         check("vec_busy_next", busy, vecs[i].e_busy);
         check("vec_missed_next", start_missed, vecs[i].e_missed);
      end

      // Full frame, data always valid.
      run_frame(1'b0, -1, 0, 1'b0);
      for (int k = 0; k < NR; k++) check("frame1_lat_time", lat_obs[k], 245 * (k + 1));
      check("frame1_busy_end", busy_obs, 980);
      @(posedge clk); #2;
      check("idle_row_en_kept", row_en, 4'b1000);
      check("idle_not_busy", busy, 0);

      // Seven-cycle data stall at row 1 bit 10.
      run_frame(1'b0, 296, 7, 1'b0);
      check("stall_row0_lat", lat_obs[0], 245);
      check("stall_row1_lat", lat_obs[1], 497);
      check("stall_busy_end", busy_obs, 987);

      // Random data_valid with a start pulse during row 2.
      run_frame(1'b1, -1, 0, 1'b1);

      // Override takeover at row 1 bit 20.
      @(posedge clk); #1;
      start = 1'b1;
      rd_if.data_valid = 1'b1;
      rd_if.data = NB'($urandom);
      for (int c = 1; c <= 346; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         rd_if.data = NB'($urandom);
         if (c == 346) begin
            hps_override = 1'b1;
            hps_SOUT     = 20'hABCDE;
            hps_row_en   = 4'b0101;
            hps_SCLK     = 1'b1;
            hps_LAT      = 1'b0;
         end
      end
      #1;
      check("ovr_state_load", state_dbg, S_LOAD);
      check("ovr_row_idx", row_idx, 1);
      check("ovr_sout", SOUT, 20'hABCDE);
      check("ovr_row_en", row_en, 4'b0101);
      check("ovr_sclk", SCLK, 1);
      check("ovr_lat", LAT, 0);
      check("ovr_data_ready", rd_if.data_ready, 0);
      @(posedge clk); #1;
      start = 1'b1;
      #1;
      check("ovr_busy_cleared", busy, 0);
      check("ovr_ready_idle", rd_if.data_ready, 0);
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check("ovr_start_no_missed", start_missed, 0);
      check("ovr_start_dropped", busy, 0);
      @(posedge clk); #1;
      hps_override = 1'b0;
      #1;
      check("ovr_rel_busy", busy, 0);
      check("ovr_rel_row_idx", row_idx, 0);
      check("ovr_rel_row_en", row_en, 0);
      check("ovr_rel_sclk", SCLK, 0);
      check("ovr_rel_lat", LAT, 0);
      check("ovr_rel_sout", SOUT, 0);

      // Asynchronous reset while LAT is high.
      @(posedge clk); #1;
      start = 1'b1;
      rd_if.data_valid = 1'b1;
      for (int c = 1; c <= 245; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      #1;
      check("pre_rst_lat", LAT, 1);
      #1;
      rst_in = 1'b1;
      #1;
      check("async_rst_lat", LAT, 0);
      check("async_rst_sclk", SCLK, 0);
      check("async_rst_row_en", row_en, 0);
      check("async_rst_busy", busy, 0);
      @(posedge clk); #1;
      rst_in = 1'b0;
      rd_if.data_valid = 1'b0;
      run_frame(1'b1, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_row_scheduler.md
Name: led_row_scheduler

Overview:
- Sequences the LED driver datapath for one multiplexed frame.
- Per mux row it does five steps in order: shift one column of band data on SOUT/SCLK, blank the rows, pulse LAT, enable the row, advance to the next row.
- Sits between the frame buffer read port and the LED band pins.
- Arbitrates pin ownership with the HPS manual-override path: when override is set, the HPS bit-bangs the pins.

Parameters:
- NB_LED_BAND, 20, number of parallel LED bands (SOUT width).
- NB_MUX_ROWS, 4, number of multiplexed rows (row_en width).
- SHIFT_BITS, 48, SCLK beats per row per band.
- SCLK_DIV, 2, clk cycles per SCLK half period (>=1).
- BLANK_CYCLES, 4, cycles all rows are off before LAT (>=1).

Ports:
- clk  in  1  system clock.
- rst_in  in  1  reset.
- start  in  1  one-cycle pulse: begin a frame (row 0).
- hps_override  in  1  1 = HPS owns the pins.
- hps_SOUT  in  NB_LED_BAND  override serial data.
- hps_SCLK  in  1  override shift clock.
- hps_LAT  in  1  override latch.
- hps_row_en  in  NB_MUX_ROWS  override row enables.
- data  in  NB_LED_BAND  one bit per band for the current beat.
- data_valid  in  1  data is valid.
- data_ready  out  1  scheduler accepts data this cycle.
- SOUT  out  NB_LED_BAND  serial data to drivers.
- SCLK  out  1  shift clock.
- LAT  out  1  latch pulse.
- row_en  out  NB_MUX_ROWS  one-hot row enable, or all zero.
- row_idx  out  clog2(NB_MUX_ROWS)  row currently being shifted.
- busy  out  1  FSM not IDLE.
- start_missed  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst_in). It forces state IDLE, row counter 0, bit counter 0, internal SOUT/SCLK/LAT/row_en 0, busy 0, start_missed 0. A reset mid-operation aborts immediately; no partial LAT is ever emitted.
- Internal pin outputs are all registered. Pin muxing is combinational: hps_override=1 puts the hps_* inputs on SOUT/SCLK/LAT/row_en.
- States: IDLE, LOAD, LOW, HIGH, BLANK, LATCH.
- IDLE:
  - busy=0.
  - start=1 (and override=0) -> LOAD with row 0, bit 0 on the next cycle.
- LOAD:
  - data_ready=1.
  - On data_valid: SOUT<=data, SCLK<=0, go to LOW.
  - Without data_valid: stay; SCLK stays 0 and SOUT holds (stall, no beat emitted).
- LOW: SCLK=0 for SCLK_DIV cycles, then SCLK<=1, go to HIGH.
- HIGH:
  - SCLK=1 for SCLK_DIV cycles, then SCLK<=0.
  - bit==SHIFT_BITS-1 -> BLANK with bit<=0; otherwise bit++ and go to LOAD.
- BLANK: row_en<=0 for BLANK_CYCLES cycles, then go to LATCH.
- LATCH:
  - LAT=1 for exactly one cycle.
  - Next cycle: LAT<=0 and row_en<=onehot(row).
  - row==NB_MUX_ROWS-1 -> row<=0, go to IDLE. Otherwise row++ and go to LOAD.
- row_en stays asserted across the next row's shift and drops only in that row's BLANK. After the final row it stays on in IDLE until the next frame's BLANK.
- Timing per beat with data_valid held high: 1 + 2*SCLK_DIV cycles (5 at default).
- Timing per row: SHIFT_BITS*(1+2*SCLK_DIV) + BLANK_CYCLES + 1 cycles (245 at default).
- start while busy: ignored; start_missed pulses in the following cycle.
- Override:
  - Rising hps_override forces the FSM to IDLE, row<=0, bit<=0, internal row_en<=0, data_ready=0.
  - A start arriving during override is dropped with no start_missed.
  - Falling override resumes with all-zero internal outputs.
- Counters: bit counter width is clog2(SHIFT_BITS); row counter wraps explicitly at NB_MUX_ROWS-1, never by overflow.

Decomposition:
- Shared package led_pkg holds:
  - the state enum sched_state_t;
  - NB_LED_BAND and NB_MUX_ROWS defaults, shared with the HPS I/O register block.
- One sub-module: sclk_gen, a divide-by-SCLK_DIV phase counter. Interface: start_beat in; phase_done and sclk_level out.

Test Plan:
- Defaults, data_valid held 1, one start:
  - 48 SCLK rising edges per row.
  - LAT high at cycles 1+245k-1 relative to start, for k=1..4, each exactly 1 cycle.
  - row_en after each LAT is 0001, 0010, 0100, 1000.
  - busy drops after 980 cycles.
- data_valid deasserted for 7 cycles at bit 10 of row 1:
  - SCLK frozen low, SOUT unchanged.
  - Row 1 LAT delayed by exactly 7 cycles; beat count still 48.
- start pulsed mid-frame (row 2): start_missed pulses once; frame completes unchanged; row sequence is not restarted.
- hps_override=1 at row 1 bit 20, hps_SOUT=0xABCDE, hps_row_en=0101:
  - Pins equal the hps values that same cycle; data_ready=0.
  - After override drops: busy=0, row_idx=0, row_en=0.
- rst_in asserted asynchronously during LATCH:
  - LAT, SCLK, row_en and busy are 0 before the next clk edge.
  - After release, start yields row 0 sequencing.
